simon32_64_key_expand: RTL and testbench
========================================

Name: simon32_64_key_expand

Overview:
- Iterative Simon32/64 key-schedule unit that sits directly upstream of the simon32_64 round datapath.
- Accepts a 64-bit master key through a valid/ready handshake and expands it into NUM_ROUNDS 16-bit round keys, one per cycle.
- Stores the round keys in an internal register file that the round datapath reads by index.
- Raises done once every round key is valid.

Parameters:
- NUM_ROUNDS, 32: number of round keys generated; legal range 5..64.
- Z_SEQ, 62'b11111010001001010110000111001101111101000100101011000011100110: Simon z0 constant. Bit z[j] is the j-th character from the left, so z[0]=1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- key_valid  input  1  master key offered this cycle.
- key_ready  output  1  block can accept a key this cycle.
- key  input  64  master key. Words: k0=key[15:0], k1=key[31:16], k2=key[47:32], k3=key[63:48].
- rk_raddr  input  6  round-key read index, 0..NUM_ROUNDS-1.
- rk_rdata  output  16  registered round-key read data.
- done  output  1  all NUM_ROUNDS keys valid and stable.

Behaviour:
- Reset values: key_ready=0, done=0, rk_rdata=16'h0000. All register-file entries, the 4-word window and the round counter i are cleared to 0. State goes to IDLE; key_ready rises in the first cycle after reset deasserts.
- States: IDLE, EXPAND, DONE.
- key_ready is 1 in IDLE and DONE and 0 in EXPAND. key_valid in EXPAND is ignored, and the key is not latched.
- Accept happens when key_valid && key_ready at a rising edge, in IDLE or DONE. On accept:
  - rf[0..3] <= k0..k3 and window w0..w3 <= k0..k3.
  - i <= 4, done <= 0, next state EXPAND.
- EXPAND, one key per cycle:
  - tmp = ROR3(w3) ^ w1; tmp = tmp ^ ROR1(tmp).
  - k_i = 16'hFFFC ^ {15'b0, Z_SEQ bit z[(i-4) mod 62]} ^ w0 ^ tmp.
  - rf[i] <= k_i; window shifts (w0<=w1, w1<=w2, w2<=w3, w3<=k_i); i <= i+1.
  - When i==NUM_ROUNDS-1 is written, next state is DONE.
- Latency: EXPAND lasts NUM_ROUNDS-4 cycles (28 at default). done is 1 starting NUM_ROUNDS-3 rising edges after the accept edge (29 at default).
- DONE:
  - done=1; register file holds its contents until the next accept.
  - A new accept in DONE overwrites rf[0..3] at that edge. done is 0 from the following cycle.
  - Other rf entries keep old values until rewritten.
- Read port:
  - rk_rdata <= rf[rk_raddr] every cycle, giving 1-cycle read latency in every state.
  - rk_raddr >= NUM_ROUNDS returns 16'h0000.
  - A read of an entry being written in the same cycle returns the old value.
  - The consumer reads only while done==1.
- Width and arithmetic: all XOR/rotate on 16 bits, no carries. ROR by n means {x[n-1:0], x[15:n]}. i is 6 bits and the z index wraps modulo 62.
- Reset mid-EXPAND: the block returns to IDLE, the register file is cleared and done stays 0. The partial key is discarded.
- Simultaneous reset and key_valid: reset wins; nothing is accepted.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> during reset key_ready=0, done=0, rk_rdata=0000; key_ready=1 the next cycle; all 32 reads return 0000.
2. Standard key: key=64'h1918111009080100 with a 1-cycle valid pulse in IDLE.
   - key_ready drops the next cycle; done rises exactly 29 edges after accept.
   - rf[0..4] = 0100, 0908, 1110, 1918, 71C3.
   - All 32 keys match the software model, and a chained simon32_64 encrypts plaintext 32'h65656877 to 32'hC69BE9BB.
3. Backpressure: keep key_valid=1 with a different key during EXPAND -> it is ignored and the result equals scenario 2. Once done rises, the held key is accepted on that edge and done falls the next cycle.
4. Reset mid-expansion: assert reset=0 at cycle 10 after accept -> state IDLE, done=0, all entries 0000. A later key expands correctly.
5. Back-to-back keys: keys 0x1918111009080100 then 0x0000000000000000, the second accepted in DONE -> the second run yields k0..k3 = 0000 and k4 = FFFD; done is 0 for 29 cycles and then returns to 1.
6. Read port: sweep rk_raddr 0..63 while done=1 -> 1-cycle latency on each read; addresses 32..63 return 0000.

Source files
------------

// File: rtl/simon32_64_key_expand.sv
// simon32_64_key_expand: iterative Simon32/64 key schedule feeding a round-key register file
module simon32_64_key_expand #(
   parameter int NUM_ROUNDS = 32,
   parameter logic [61:0] Z_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key,
   input  logic [5:0]  rk_raddr,
   output logic [15:0] rk_rdata,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
   state_t state, state_nx;
   logic [15:0] rf [64];
   logic [15:0] w0, w1, w2, w3, tmp0, tmp, k_i;
   logic [5:0]  i, zi, zidx;
   logic        accept;
   assign accept = key_valid && key_ready;
   assign tmp0   = {w3[2:0], w3[15:3]} ^ w1;
   assign tmp    = tmp0 ^ {tmp0[0], tmp0[15:1]};
   assign zi     = i - 6'd4;
   assign zidx   = zi >= 6'd62 ? zi - 6'd62 : zi;
   assign k_i    = 16'hFFFC ^ {15'b0, Z_SEQ[6'd61 - zidx]} ^ w0 ^ tmp;
   always_comb begin
      state_nx = accept ? EXPAND : (state == EXPAND && i == 6'(NUM_ROUNDS - 1)) ? DONE : state;
   end
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end
   // entries at or above NUM_ROUNDS are never written, so they read back as zero
   always_ff @(posedge clk) begin
      if (!reset) begin
         key_ready <= 1'b0;
         done      <= 1'b0;
         rk_rdata  <= '0;
         i         <= '0;
         w0        <= '0;
         w1        <= '0;
         w2        <= '0;
         w3        <= '0;
         for (int n = 0; n < 64; n++) rf[n] <= '0;
      end else begin
         rk_rdata  <= rf[rk_raddr];
         key_ready <= !accept && state != EXPAND;
         done      <= !accept && state == DONE;
         if (accept) begin
            rf[0] <= key[15:0];
            rf[1] <= key[31:16];
            rf[2] <= key[47:32];
            rf[3] <= key[63:48];
            w0    <= key[15:0];
            w1    <= key[31:16];
            w2    <= key[47:32];
            w3    <= key[63:48];
            i     <= 6'd4;
         end else if (state == EXPAND) begin
            rf[i] <= k_i;
            w0    <= w1;
            w1    <= w2;
            w2    <= w3;
            w3    <= k_i;
            i     <= i + 6'd1;
         end
      end
   end
endmodule

// File: tb/tb_simon32_64_key_expand.sv
// tb_simon32_64_key_expand: scoreboard bench; reads are checked against an array-based Simon key schedule model
module tb_simon32_64_key_expand;
   localparam int NR = 32;
   typedef logic [15:0] rk_t [64];
   typedef struct {logic [5:0] addr; logic [15:0] exp;} rd_t;

   logic        clk_tb = 1'b0;
   logic        reset = 1'b0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [63:0] key = '0;
   logic [5:0]  rk_raddr = '0;
   logic [15:0] rk_rdata;
   logic        done;
   logic        rd_req = 1'b0;
   logic        rd_q = 1'b0;
   int          tests = 0;
   int          fails = 0;
   rd_t         sb[$];
   rk_t         dut_rk;
   rk_t         zero_rk;
   string       zs = "11111010001001010110000111001101111101000100101011000011100110";

   simon32_64_key_expand dut (
      .clk(clk_tb), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
      .key(key), .rk_raddr(rk_raddr), .rk_rdata(rk_rdata), .done(done)
   );

   always #5 clk_tb = ~clk_tb;
   always @(posedge clk_tb) rd_q <= rd_req;

   function automatic logic [15:0] ror(input logic [15:0] x, input int n);
      return 16'((x >> n) | (x << (16 - n)));
   endfunction

   // classic reference form: k[i] = ~k[i-4] ^ 3 ^ z ^ f(k[i-1], k[i-3])
   function automatic rk_t expand(input logic [63:0] k);
      rk_t r;
      logic [15:0] t;
      for (int n = 0; n < 64; n++) r[n] = '0;
      for (int n = 0; n < 4; n++) r[n] = k[16*n +: 16];
      for (int n = 4; n < NR; n++) begin
         t = ror(r[n-1], 3) ^ r[n-3];
         t = t ^ ror(t, 1);
         r[n] = ~r[n-4] ^ 16'd3 ^ {15'b0, zs[(n-4) % 62] == "1"} ^ t;
      end
      return r;
   endfunction

   function automatic logic [31:0] encrypt(input logic [31:0] pt, input rk_t ks);
      logic [15:0] x, y, t;
      x = pt[31:16];
      y = pt[15:0];
      for (int r = 0; r < NR; r++) begin
         t = x;
         x = y ^ ((ror(x, 15) & ror(x, 8)) ^ ror(x, 14)) ^ ks[r];
         y = t;
      end
      return {x, y};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk_tb) begin
      if (rd_q) begin
         if (sb.size() == 0) chk("scoreboard_underflow", 64'd1, 64'd0);
         else begin
            rd_t e;
            e = sb.pop_front();
            chk($sformatf("rk[%0d]", e.addr), 64'(rk_rdata), 64'(e.exp));
            dut_rk[e.addr] = rk_rdata;
         end
      end
   end

   task automatic tick();
      @(negedge clk_tb);
   endtask

   task automatic send_key(input logic [63:0] k, input bit hold);
      int c = 0;
      key = k;
      key_valid = 1'b1;
      while (!key_ready && c < 200) begin
         tick();
         c++;
      end
      if (c >= 200) chk("key_ready_timeout", 64'd0, 64'd1);
      tick();
      if (!hold) key_valid = 1'b0;
      chk("key_ready_drop", 64'(key_ready), 64'd0);
   endtask

   task automatic wait_done(input int exp_cyc);
      int c = 0;
      while (!done && c < 200) begin
         tick();
         c++;
      end
      chk("done_latency", 64'(c), 64'(exp_cyc));
   endtask

   task automatic sweep(input rk_t exp);
      for (int a = 0; a < 64; a++) begin
         rk_raddr = 6'(a);
         rd_req = 1'b1;
         sb.push_back('{addr: 6'(a), exp: exp[a]});
         tick();
      end
      rd_req = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] k1, k2, k3;
      rk_t m;
      for (int n = 0; n < 64; n++) zero_rk[n] = '0;
      // reset held low for 2 cycles
      tick();
      chk("rst_key_ready", 64'(key_ready), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rdata", 64'(rk_rdata), 64'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("post_rst_key_ready", 64'(key_ready), 64'd1);
      sweep(zero_rk);

      // standard test vector
      k1 = 64'h1918111009080100;
      send_key(k1, 1'b0);
      wait_done(29);
      sweep(expand(k1));
      chk("rf0", 64'(dut_rk[0]), 64'h0100);
      chk("rf1", 64'(dut_rk[1]), 64'h0908);
      chk("rf2", 64'(dut_rk[2]), 64'h1110);
      chk("rf3", 64'(dut_rk[3]), 64'h1918);
      chk("rf4", 64'(dut_rk[4]), 64'h71C3);
      chk("encrypt", 64'(encrypt(32'h65656877, dut_rk)), 64'hC69BE9BB);

      // held key_valid during EXPAND is ignored, then accepted once done
      k2 = {$urandom, $urandom};
      send_key(k1, 1'b1);
      key = k2;
      wait_done(29);
      chk("bp_key_ready", 64'(key_ready), 64'd1);
      m = expand(k1);
      rk_raddr = 6'd31;
      rd_req = 1'b1;
      sb.push_back('{addr: 6'd31, exp: m[31]});
      tick();
      rd_req = 1'b0;
      key_valid = 1'b0;
      chk("bp_done_fall", 64'(done), 64'd0);
      chk("bp_accept", 64'(key_ready), 64'd0);
      wait_done(29);
      sweep(expand(k2));

      // reset in the middle of expansion
      k3 = {$urandom, $urandom};
      send_key(k3, 1'b0);
      repeat (9) tick();
      reset = 1'b0;
      tick();
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_key_ready", 64'(key_ready), 64'd0);
      reset = 1'b1;
      tick();
      chk("mid_rst_idle", 64'(key_ready), 64'd1);
      chk("mid_rst_done2", 64'(done), 64'd0);
      sweep(zero_rk);
      send_key(k3, 1'b0);
      wait_done(29);
      sweep(expand(k3));

      // back-to-back: all-zero key accepted in DONE
      send_key(k1, 1'b0);
      wait_done(29);
      send_key(64'd0, 1'b0);
      chk("b2b_done_low", 64'(done), 64'd0);
      wait_done(29);
      sweep(expand(64'd0));
      chk("zero_k0", 64'(dut_rk[0]), 64'h0000);
      chk("zero_k3", 64'(dut_rk[3]), 64'h0000);
      chk("zero_k4", 64'(dut_rk[4]), 64'hFFFD);

      // random keys with random idle gaps
      for (int t = 0; t < 4; t++) begin
         k3 = {$urandom, $urandom};
         repeat ($urandom_range(0, 3)) tick();
         send_key(k3, 1'b0);
         wait_done(29);
         sweep(expand(k3));
      end

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
